pipeline_elastic_deliver: RTL and testbench

- Parametrised successor to the single-register stall/flush pipeline latch.
- Adds a valid/ready handshake, a DEPTH-entry elastic buffer (so the upstream stage keeps issuing while downstream stalls), bubble insertion, flush and an occupancy report.
- Sits between any two core pipeline stages (e.g. decode→rename, rename→issue). Stall propagation becomes local ready back-pressure instead of global stall wires.

---
 rtl/pipeline_elastic_deliver.sv | 147 ++++++++++++++
 tb/tb_pipeline_elastic_deliver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_elastic_deliver.sv
// Elastic pipeline register: DEPTH-entry circular buffer with a valid/ready
// handshake on both sides, bubble value on idle output, flush and occupancy.

// Simulation-only invariants on the buffer's occupancy and pop legality.
module pipeline_elastic_deliver_chk #(
   parameter int DEPTH = 2,
   parameter int CW    = 2
) (
   input logic          clk,
   input logic          rst,
   input logic          pop,
   input logic [CW-1:0] count
);

   // Occupancy can never grow beyond the number of storage entries.
   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count <= CW'(DEPTH));

   // A pop is only meaningful when there is something to pop.
   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
      pop |-> (count != {CW{1'b0}}));

endmodule

module pipeline_elastic_deliver #(
   parameter int               WIDTH      = 32,
   parameter int               DEPTH      = 2,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
   parameter int               AF_MARGIN  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wp_r;
   logic [PW-1:0]    rp_r;
   logic [CW-1:0]    count_r;

   logic             push_s;
   logic             pop_s;
   logic [PW-1:0]    wp_inc_s;
   logic [PW-1:0]    rp_inc_s;
   logic [PW-1:0]    wp_nxt_s;
   logic [PW-1:0]    rp_nxt_s;
   logic [CW-1:0]    count_nxt_s;

   // Handshake and status outputs depend only on registered state, so
   // out_ready never reaches in_ready combinationally.
   always_comb begin
      in_ready    = (count_r != CW'(DEPTH));
      out_valid   = (count_r != {CW{1'b0}});
      count       = count_r;
      almost_full = (count_r >= CW'(DEPTH - AF_MARGIN));
      if (out_valid) begin
         out_data = mem_r[rp_r];
      end else begin
         out_data = BUBBLE_VAL;
      end
   end

   // Transfer qualifiers and pointer increments with explicit wrap at DEPTH-1,
   // so non-power-of-two depths never address a missing entry.
   always_comb begin
      push_s = in_valid & in_ready;
      pop_s  = out_valid & out_ready;
      if (wp_r == PW'(DEPTH - 1)) begin
         wp_inc_s = {PW{1'b0}};
      end else begin
         wp_inc_s = wp_r + PW'(1);
      end
      if (rp_r == PW'(DEPTH - 1)) begin
         rp_inc_s = {PW{1'b0}};
      end else begin
         rp_inc_s = rp_r + PW'(1);
      end
   end

   // Next-state for pointers and occupancy during normal operation.
   always_comb begin
      wp_nxt_s    = wp_r;
      rp_nxt_s    = rp_r;
      count_nxt_s = count_r;
      if (push_s) begin
         wp_nxt_s = wp_inc_s;
      end else begin
         wp_nxt_s = wp_r;
      end
      if (pop_s) begin
         rp_nxt_s = rp_inc_s;
      end else begin
         rp_nxt_s = rp_r;
      end
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointer/occupancy registers; reset beats flush, flush beats traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_r    <= {PW{1'b0}};
         rp_r    <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (flush) begin
         wp_r    <= {PW{1'b0}};
         rp_r    <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         wp_r    <= wp_nxt_s;
         rp_r    <= rp_nxt_s;
         count_r <= count_nxt_s;
      end
   end

   // Payload storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push_s && !rst && !flush) begin
         mem_r[wp_r] <= in_data;
      end
   end

   pipeline_elastic_deliver_chk #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_chk (
      .clk   (clk),
      .rst   (rst),
      .pop   (pop_s),
      .count (count_r)
   );

endmodule

// File: tb/tb_pipeline_elastic_deliver.sv
// Self-checking bench: two instances (DEPTH=2 and DEPTH=3) share the same
// stimulus and are compared against queue-based reference models.
module tb_pipeline_elastic_deliver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'h0;
   logic        out_ready = 1'b0;

   logic        ir2, ov2, af2, ir3, ov3, af3;
   logic [31:0] od2, od3;
   logic [1:0]  cnt2, cnt3;

   logic [31:0] q2 [$];
   logic [31:0] q3 [$];

   int chk_cnt  = 0;
   int pass_cnt = 0;

   wire [36:0] act2 = {ir2, ov2, od2, cnt2, af2};
   wire [36:0] act3 = {ir3, ov3, od3, cnt3, af3};
   logic [36:0] idle_exp = {1'b1, 1'b0, 32'h0, 2'd0, 1'b0};

   always #5 clk = ~clk;

   pipeline_elastic_deliver #(.WIDTH(32), .DEPTH(2), .BUBBLE_VAL(32'h0), .AF_MARGIN(1)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
      .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
      .count(cnt2), .almost_full(af2));

   pipeline_elastic_deliver #(.WIDTH(32), .DEPTH(3), .BUBBLE_VAL(32'h0), .AF_MARGIN(1)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
      .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
      .count(cnt3), .almost_full(af3));

   // Expected {in_ready, out_valid, out_data, count, almost_full} from a model queue.
   function automatic logic [36:0] expv(input int d);
      int          sz;
      logic [31:0] head;
      if (d == 2) begin
         sz   = q2.size();
         head = (sz != 0) ? q2[0] : 32'h0;
      end else begin
         sz   = q3.size();
         head = (sz != 0) ? q3[0] : 32'h0;
      end
      return {(sz != d), (sz != 0), head, 2'(sz), (sz >= d - 1)};
   endfunction

   // One clock: advance both reference models with the inputs seen at the edge.
   task automatic tick();
      int  sz;
      logic pu, po;
      @(posedge clk);
      sz = q2.size();
      if (rst || flush) q2.delete();
      else begin
         po = (sz != 0) && out_ready;
         pu = in_valid && (sz != 2);
         if (po) void'(q2.pop_front());
         if (pu) q2.push_back(in_data);
      end
      sz = q3.size();
      if (rst || flush) q3.delete();
      else begin
         po = (sz != 0) && out_ready;
         pu = in_valid && (sz != 3);
         if (po) void'(q3.pop_front());
         if (pu) q3.push_back(in_data);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk_cnt++;
      if (act2 !== idle_exp) $display("FAIL reset_d2 act=%h exp=%h", act2, idle_exp);
      else pass_cnt++;
      chk_cnt++;
      if (act3 !== idle_exp) $display("FAIL reset_d3 act=%h exp=%h", act3, idle_exp);
      else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_streaming();
      logic [31:0] vals [3];
      vals = '{32'h11, 32'h22, 32'h33};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = vals[i];
         tick();
         chk_cnt++;
         if ({ov2, od2, cnt2, ir2} !== {1'b1, vals[i], 2'd1, 1'b1})
            $display("FAIL stream_d2_%0d act=%b/%h/%0d/%b exp=1/%h/1/1", i, ov2, od2, cnt2, ir2, vals[i]);
         else pass_cnt++;
         chk_cnt++;
         if (act3 !== expv(3)) $display("FAIL stream_d3_%0d act=%h exp=%h", i, act3, expv(3));
         else pass_cnt++;
      end
      in_valid = 1'b0;
      tick();
      chk_cnt++;
      if (act2 !== idle_exp) $display("FAIL stream_drain act=%h exp=%h", act2, idle_exp);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [31:0] vals [3];
      logic [31:0] drain [4];
      vals  = '{32'hA, 32'hB, 32'hC};
      drain = '{32'hB, 32'hC, 32'hD, 32'h0};
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = vals[i];
         tick();
         chk_cnt++;
         if ({cnt3, af3, ir3} !== {2'(i + 1), (i >= 1), (i != 2)})
            $display("FAIL fill_%0d act=%0d/%b/%b exp=%0d/%b/%b", i, cnt3, af3, ir3, i + 1, (i >= 1), (i != 2));
         else pass_cnt++;
      end
      in_data = 32'hD;
      tick();
      chk_cnt++;
      if ({cnt3, ir3, od3} !== {2'd3, 1'b0, 32'hA})
         $display("FAIL full_hold act=%0d/%b/%h exp=3/0/a", cnt3, ir3, od3);
      else pass_cnt++;
      chk_cnt++;
      if (act2 !== expv(2)) $display("FAIL full_d2 act=%h exp=%h", act2, expv(2));
      else pass_cnt++;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 1) in_valid = 1'b0;
         chk_cnt++;
         if (od3 !== drain[i] || ov3 !== (i != 3))
            $display("FAIL drain_%0d act=%b/%h exp=%b/%h", i, ov3, od3, (i != 3), drain[i]);
         else pass_cnt++;
         chk_cnt++;
         if (act2 !== expv(2)) $display("FAIL drain_d2_%0d act=%h exp=%h", i, act2, expv(2));
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap();
      logic [31:0] sent [$];
      logic [31:0] got [$];
      int n = 0;
      int cyc = 0;
      while ((n < 10 || q3.size() != 0) && cyc < 100) begin
         out_ready = (cyc % 2 == 0);
         in_valid  = (n < 10);
         in_data   = $urandom;
         if (ov3 && out_ready) got.push_back(od3);
         if (in_valid && q3.size() != 3) begin
            sent.push_back(in_data);
            n++;
         end
         tick();
         cyc++;
         chk_cnt++;
         if (act3 !== expv(3) || cnt3 > 2'd3) $display("FAIL wrap_d3_c%0d act=%h exp=%h", cyc, act3, expv(3));
         else pass_cnt++;
         chk_cnt++;
         if (act2 !== expv(2)) $display("FAIL wrap_d2_c%0d act=%h exp=%h", cyc, act2, expv(2));
         else pass_cnt++;
      end
      in_valid = 1'b0;
      chk_cnt++;
      if (got.size() != 10 || cyc >= 100) $display("FAIL wrap_count act=%0d exp=10 cycles=%0d", got.size(), cyc);
      else pass_cnt++;
      for (int i = 0; i < 10 && i < got.size(); i++) begin
         chk_cnt++;
         if (got[i] !== sent[i]) $display("FAIL wrap_order_%0d act=%h exp=%h", i, got[i], sent[i]);
         else pass_cnt++;
      end
      tick(); tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 32'h5; tick();
      in_data = 32'h6; tick();
      chk_cnt++;
      if ({cnt3, od3} !== {2'd2, 32'h5}) $display("FAIL flush_pre act=%0d/%h exp=2/5", cnt3, od3);
      else pass_cnt++;
      flush = 1'b1; in_data = 32'h7; out_ready = 1'b1;
      tick();
      chk_cnt++;
      if (act3 !== idle_exp) $display("FAIL flush_d3 act=%h exp=%h", act3, idle_exp);
      else pass_cnt++;
      chk_cnt++;
      if (act2 !== idle_exp) $display("FAIL flush_d2 act=%h exp=%h", act2, idle_exp);
      else pass_cnt++;
      flush = 1'b0; in_data = 32'h8; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk_cnt++;
      if ({ov3, od3, cnt3} !== {1'b1, 32'h8, 2'd1}) $display("FAIL flush_next act=%b/%h/%0d exp=1/8/1", ov3, od3, cnt3);
      else pass_cnt++;
   endtask

   task automatic test_reset_over_flush();
      in_valid = 1'b1; in_data = 32'h1; out_ready = 1'b0;
      tick();
      chk_cnt++;
      if ({cnt3, cnt2} !== {2'd2, 2'd2}) $display("FAIL rf_pre act=%0d/%0d exp=2/2", cnt3, cnt2);
      else pass_cnt++;
      rst = 1'b1; flush = 1'b1; in_data = 32'h55; out_ready = 1'b1;
      tick();
      chk_cnt++;
      if ({act3, act2} !== {idle_exp, idle_exp}) $display("FAIL rf_state act=%h/%h exp=%h", act3, act2, idle_exp);
      else pass_cnt++;
      rst = 1'b0; flush = 1'b0; in_data = 32'h9; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk_cnt++;
      if ({od3, od2, cnt3} !== {32'h9, 32'h9, 2'd1}) $display("FAIL rf_first act=%h/%h/%0d exp=9/9/1", od3, od2, cnt3);
      else pass_cnt++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = $urandom;
         flush     = ($urandom_range(0, 31) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         tick();
         chk_cnt++;
         if (act2 !== expv(2)) $display("FAIL rand_d2_c%0d act=%h exp=%h", c, act2, expv(2));
         else pass_cnt++;
         chk_cnt++;
         if (act3 !== expv(3)) $display("FAIL rand_d3_c%0d act=%h exp=%h", c, act3, expv(3));
         else pass_cnt++;
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_wrap();
      test_flush();
      test_reset_over_flush();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
